// File: rtl/mem_arbiter.sv
// Shared SRAM port arbiter: loader > DMA > CPU, with a CPU anti-starvation guard
// and a stuck-access timeout. One held mem_req transaction is in flight at a time.
module mem_arbiter #(
  parameter int AW      = 25,
  parameter int TIMEOUT = 63,
  parameter int STARVE  = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_din,
  output logic          ld_ack,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  output logic          dma_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_ack,
  output logic [7:0]    rdata,
  output logic [1:0]    grant,
  output logic          timeout_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic          mem_ack,
  input  logic [7:0]    mem_dout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE + 1);

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_CPU  = 2'b01;
  localparam logic [1:0] G_DMA  = 2'b10;
  localparam logic [1:0] G_LD   = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q;
  logic [1:0]    grant_q;
  logic          mem_req_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [7:0]    mem_din_q;
  logic [7:0]    rdata_q;
  logic          ld_ack_q, dma_ack_q, cpu_ack_q;
  logic          timeout_err_q;
  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_inc;
  logic [SW-1:0] starve_q;
  logic          starved;
  logic [1:0]    win;

  assign starved  = (starve_q == SW'(STARVE));
  assign tcnt_inc = tcnt_q + 1'b1;

  // The CPU jumps ahead of the DMA only once the guard has saturated.
  always_comb begin
    win = G_NONE;
    if (ld_req)                  win = G_LD;
    else if (cpu_req && starved) win = G_CPU;
    else if (dma_req)            win = G_DMA;
    else if (cpu_req)            win = G_CPU;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_q       <= G_NONE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= 8'h00;
      rdata_q       <= 8'h00;
      ld_ack_q      <= 1'b0;
      dma_ack_q     <= 1'b0;
      cpu_ack_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      tcnt_q        <= '0;
      starve_q      <= '0;
    end else begin
      ld_ack_q  <= 1'b0;
      dma_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!cpu_req) starve_q <= '0;
          if (win != G_NONE) begin
            grant_q   <= win;
            mem_req_q <= 1'b1;
            tcnt_q    <= '0;
            state_q   <= ACCESS;
            case (win)
              G_LD: begin
                mem_addr_q <= ld_addr;
                mem_we_q   <= 1'b1;
                mem_din_q  <= ld_din;
              end
              G_DMA: begin
                mem_addr_q <= dma_addr;
                mem_we_q   <= 1'b0;
                mem_din_q  <= 8'h00;
              end
              default: begin
                mem_addr_q <= cpu_addr;
                mem_we_q   <= cpu_we;
                mem_din_q  <= cpu_din;
              end
            endcase
            if (win == G_CPU)
              starve_q <= '0;
            else if (win == G_DMA && cpu_req && !starved)
              starve_q <= starve_q + 1'b1;
          end
        end
        ACCESS: begin
          // A real ack on the terminal cycle takes precedence over the abort.
          if (mem_ack || tcnt_inc == TW'(TIMEOUT)) begin
            mem_req_q <= 1'b0;
            state_q   <= DONE;
            ld_ack_q  <= (grant_q == G_LD);
            dma_ack_q <= (grant_q == G_DMA);
            cpu_ack_q <= (grant_q == G_CPU);
            if (mem_ack) begin
              if (!mem_we_q) rdata_q <= mem_dout;
            end else begin
              rdata_q       <= 8'hFF;
              timeout_err_q <= 1'b1;
            end
          end else begin
            tcnt_q <= tcnt_inc;
          end
        end
        DONE: begin
          grant_q <= G_NONE;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ld_ack      = ld_ack_q;
  assign dma_ack     = dma_ack_q;
  assign cpu_ack     = cpu_ack_q;
  assign rdata       = rdata_q;
  assign grant       = grant_q;
  assign timeout_err = timeout_err_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural SRAM, protocol monitor and a
// transaction-level arbitration model driven with randomized request mixes.
module tb_mem_arbiter;
  localparam int AW      = 25;
  localparam int TIMEOUT = 63;
  localparam int STARVE  = 4;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          ld_req = 1'b0, dma_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] ld_addr = '0, dma_addr = '0, cpu_addr = '0;
  logic [7:0]    ld_din = 8'h00, cpu_din = 8'h00;
  logic          ld_ack, dma_ack, cpu_ack, timeout_err;
  logic [7:0]    rdata;
  logic [1:0]    grant;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_dout = 8'h00;

  mem_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT), .STARVE(STARVE)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_din(ld_din), .ld_ack(ld_ack),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .rdata(rdata), .grant(grant), .timeout_err(timeout_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ack(mem_ack), .mem_dout(mem_dout)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [7:0]    din;
  } op_t;

  int checks = 0, errors = 0;
  op_t ld_ops[$], dma_ops[$], cpu_ops[$], sram_log[$];
  int grant_q[$], len_q[$], exp_q[$];
  int multi_ack = 0, ack_grant_bad = 0, long_ack = 0, unstable = 0;
  int sram_lat = 1;
  bit sram_dead = 1'b0;
  bit ovr_en = 1'b0;
  logic [7:0] ovr_val = 8'h00;

  function automatic logic [7:0] fdata(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[24:17] ^ 8'h3C;
  endfunction

  // SRAM: acks on the sram_lat-th cycle of mem_req, or never when dead.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk_sys);
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_req) begin
        cnt++;
        if (!sram_dead && cnt == sram_lat) begin
          op_t o;
          o.addr = mem_addr; o.we = mem_we; o.din = mem_din;
          sram_log.push_back(o);
          mem_ack  = 1'b1;
          mem_dout = mem_we ? 8'($urandom) : (ovr_en ? ovr_val : fdata(mem_addr));
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Protocol monitor: grant sequence, mem_req run lengths, ack sanity.
  initial begin
    logic [1:0]    pg = 2'b00;
    bit            pa = 1'b0, preq = 1'b0;
    logic [AW-1:0] pad = '0;
    logic          pwe = 1'b0;
    logic [7:0]    pdin = 8'h00;
    int            run = 0;
    int            n;
    forever begin
      @(negedge clk_sys);
      if (grant != 2'b00 && pg == 2'b00) grant_q.push_back(int'(grant));
      n = int'(ld_ack) + int'(dma_ack) + int'(cpu_ack);
      if (n > 1) multi_ack++;
      if ((ld_ack && grant != 2'b11) || (dma_ack && grant != 2'b10) ||
          (cpu_ack && grant != 2'b01)) ack_grant_bad++;
      if (n > 0 && pa) long_ack++;
      if (mem_req && preq && (mem_addr !== pad || mem_we !== pwe || mem_din !== pdin))
        unstable++;
      if (mem_req) run++;
      else if (run > 0) begin len_q.push_back(run); run = 0; end
      pg = grant; pa = (n > 0); preq = mem_req;
      pad = mem_addr; pwe = mem_we; pdin = mem_din;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transaction-level arbitration: each requester has a count of back-to-back
  // transactions, all raised together; returns the grant order in exp_q.
  task automatic model_grants(input int nl, input int nd, input int nc);
    int st = 0;
    exp_q.delete();
    while (nl + nd + nc > 0) begin
      if (nl > 0) begin
        exp_q.push_back(3); nl--;
      end else if (nc > 0 && (st == STARVE || nd == 0)) begin
        exp_q.push_back(1); nc--; st = 0;
      end else begin
        exp_q.push_back(2); nd--;
        if (nc > 0 && st < STARVE) st++;
      end
      if (nc == 0) st = 0;
    end
  endtask

  task automatic drive_ld(input int n);
    for (int k = 0; k < n; k++) begin
      op_t o;
      int t;
      o.addr = AW'($urandom); o.we = 1'b1; o.din = 8'($urandom);
      ld_ops.push_back(o);
      ld_addr = o.addr; ld_din = o.din; ld_req = 1'b1;
      for (t = 0; t < 400; t++) begin @(negedge clk_sys); if (ld_ack) break; end
      checks++;
      if (!ld_ack) begin errors++; $display("FAIL ld_ack_wait: got no ack want ack within 400 cycles"); end
    end
    ld_req = 1'b0;
  endtask

  task automatic drive_dma(input int n);
    for (int k = 0; k < n; k++) begin
      op_t o;
      int t;
      o.addr = AW'($urandom); o.we = 1'b0; o.din = 8'h00;
      dma_ops.push_back(o);
      dma_addr = o.addr; dma_req = 1'b1;
      for (t = 0; t < 400; t++) begin @(negedge clk_sys); if (dma_ack) break; end
      checks++;
      if (!dma_ack) begin errors++; $display("FAIL dma_ack_wait: got no ack want ack within 400 cycles"); end
      else if (rdata !== fdata(o.addr)) begin
        errors++; $display("FAIL dma_rdata: got %h want %h", rdata, fdata(o.addr));
      end
    end
    dma_req = 1'b0;
  endtask

  task automatic drive_cpu(input int n);
    for (int k = 0; k < n; k++) begin
      op_t o;
      int t;
      o.addr = AW'($urandom); o.we = 1'($urandom); o.din = 8'($urandom);
      cpu_ops.push_back(o);
      cpu_addr = o.addr; cpu_we = o.we; cpu_din = o.din; cpu_req = 1'b1;
      for (t = 0; t < 400; t++) begin @(negedge clk_sys); if (cpu_ack) break; end
      checks++;
      if (!cpu_ack) begin errors++; $display("FAIL cpu_ack_wait: got no ack want ack within 400 cycles"); end
      else if (!o.we && rdata !== fdata(o.addr)) begin
        errors++; $display("FAIL cpu_rdata: got %h want %h", rdata, fdata(o.addr));
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic run_mix(input int nl, input int nd, input int nc);
    int il = 0, id = 0, ic = 0;
    ld_ops.delete(); dma_ops.delete(); cpu_ops.delete();
    sram_log.delete(); grant_q.delete();
    @(negedge clk_sys);
    fork
      drive_ld(nl);
      drive_dma(nd);
      drive_cpu(nc);
    join
    repeat (3) @(negedge clk_sys);
    model_grants(nl, nd, nc);
    checks++;
    if (grant_q.size() != exp_q.size() || sram_log.size() != exp_q.size()) begin
      errors++;
      $display("FAIL mix_count: got %0d grants %0d accesses want %0d", grant_q.size(), sram_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      op_t e;
      if (exp_q[i] == 3) e = ld_ops[il++];
      else if (exp_q[i] == 2) e = dma_ops[id++];
      else e = cpu_ops[ic++];
      if (i < grant_q.size()) begin
        checks++;
        if (grant_q[i] != exp_q[i]) begin
          errors++; $display("FAIL mix_grant[%0d]: got %0d want %0d", i, grant_q[i], exp_q[i]);
        end
      end
      if (i < sram_log.size()) begin
        checks++;
        if (sram_log[i].addr !== e.addr || sram_log[i].we !== e.we ||
            (e.we && sram_log[i].din !== e.din)) begin
          errors++;
          $display("FAIL mix_access[%0d]: got %h/%b/%h want %h/%b/%h", i, sram_log[i].addr,
                   sram_log[i].we, sram_log[i].din, e.addr, e.we, e.din);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_req, mem_we, ld_ack, dma_ack, cpu_ack, timeout_err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {mem_req, mem_we, ld_ack, dma_ack, cpu_ack, timeout_err});
    end
    checks++;
    if (grant !== 2'b00 || rdata !== 8'h00) begin
      errors++; $display("FAIL reset_grant_rdata: got %b/%h want 00/00", grant, rdata);
    end
    checks++;
    if (mem_addr !== '0 || mem_din !== 8'h00) begin
      errors++; $display("FAIL reset_mem_bus: got %h/%h want 0/00", mem_addr, mem_din);
    end
  endtask

  task automatic test_cpu_write();
    int t;
    sram_lat = 4; len_q.delete(); sram_log.delete();
    @(negedge clk_sys);
    cpu_we = 1'b1; cpu_addr = 25'h00123; cpu_din = 8'h5A; cpu_req = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (grant !== 2'b01 || mem_req !== 1'b1) begin
      errors++; $display("FAIL cpu_wr_grant: got %b/%b want 01/1", grant, mem_req);
    end
    for (t = 2; t <= 20; t++) begin @(negedge clk_sys); if (cpu_ack) break; end
    checks++;
    if (t != 5) begin errors++; $display("FAIL cpu_wr_latency: got %0d want 5", t); end
    checks++;
    if (rdata !== 8'h00 || ld_ack !== 1'b0 || dma_ack !== 1'b0) begin
      errors++; $display("FAIL cpu_wr_rdata: got %h/%b/%b want 00/0/0", rdata, ld_ack, dma_ack);
    end
    cpu_req = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (grant !== 2'b00 || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL cpu_wr_release: got %b/%b want 00/0", grant, cpu_ack);
    end
    checks++;
    if (len_q.size() != 1 || len_q[0] != 4) begin
      errors++; $display("FAIL cpu_wr_reqlen: got %0d entries want one of 4", len_q.size());
    end
    checks++;
    if (sram_log.size() != 1 || sram_log[0].addr !== 25'h00123 ||
        sram_log[0].din !== 8'h5A || sram_log[0].we !== 1'b1) begin
      errors++; $display("FAIL cpu_wr_access: got %0d accesses want 00123/5A/1", sram_log.size());
    end
  endtask

  task automatic test_dma_read();
    int t;
    sram_lat = 3; ovr_en = 1'b1; ovr_val = 8'hC3;
    @(negedge clk_sys);
    dma_addr = 25'h0E000; dma_req = 1'b1;
    for (t = 1; t <= 20; t++) begin @(negedge clk_sys); if (dma_ack) break; end
    checks++;
    if (!dma_ack || rdata !== 8'hC3 || cpu_ack !== 1'b0 || ld_ack !== 1'b0) begin
      errors++; $display("FAIL dma_read: got ack %b rdata %h want ack 1 rdata c3", dma_ack, rdata);
    end
    dma_req = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (dma_ack !== 1'b0) begin errors++; $display("FAIL dma_ack_pulse: got %b want 0", dma_ack); end
    ovr_en = 1'b0;
  endtask

  task automatic test_priority();
    sram_lat = 2;
    run_mix(1, 1, 1);
    checks++;
    if (grant_q.size() != 3 || grant_q[0] != 3 || grant_q[1] != 2 || grant_q[2] != 1) begin
      errors++; $display("FAIL priority_order: got %0d grants want order 3,2,1", grant_q.size());
    end
  endtask

  task automatic test_starvation();
    int want[$] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1, 2, 2, 2};
    sram_lat = 1;
    run_mix(0, 12, 2);
    for (int i = 0; i < want.size() && i < grant_q.size(); i++) begin
      checks++;
      if (grant_q[i] != want[i]) begin
        errors++; $display("FAIL starve_seq[%0d]: got %0d want %0d", i, grant_q[i], want[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 15; it++) begin
      int nl, nd, nc;
      nl = $urandom_range(0, 2); nd = $urandom_range(0, 6); nc = $urandom_range(0, 3);
      if (nl + nd + nc == 0) nd = 1;
      sram_lat = $urandom_range(1, 5);
      run_mix(nl, nd, nc);
    end
  endtask

  task automatic test_timeout();
    int t;
    sram_dead = 1'b1; len_q.delete();
    @(negedge clk_sys);
    cpu_we = 1'b0; cpu_addr = AW'($urandom); cpu_req = 1'b1;
    for (t = 1; t <= 100; t++) begin @(negedge clk_sys); if (cpu_ack) break; end
    checks++;
    if (t != TIMEOUT + 1) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", t, TIMEOUT + 1); end
    checks++;
    if (rdata !== 8'hFF || timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_abort: got %h/%b want ff/1", rdata, timeout_err);
    end
    cpu_req = 1'b0; sram_dead = 1'b0; sram_lat = 2;
    @(negedge clk_sys);
    checks++;
    if (len_q.size() != 1 || len_q[0] != TIMEOUT) begin
      errors++; $display("FAIL timeout_reqlen: got %0d entries want one of %0d", len_q.size(), TIMEOUT);
    end
    run_mix(0, 1, 0);
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
    do_reset();
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
  endtask

  task automatic test_coincide();
    int t;
    sram_lat = TIMEOUT;
    @(negedge clk_sys);
    cpu_we = 1'b0; cpu_addr = 25'h00155; cpu_req = 1'b1;
    for (t = 1; t <= 100; t++) begin @(negedge clk_sys); if (cpu_ack) break; end
    checks++;
    if (t != TIMEOUT + 1 || rdata !== fdata(25'h00155) || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL coincide: got t=%0d rdata %h err %b want t=%0d rdata %h err 0", t, rdata,
               timeout_err, TIMEOUT + 1, fdata(25'h00155));
    end
    cpu_req = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_reset_mid();
    int t;
    sram_dead = 1'b1;
    @(negedge clk_sys);
    dma_addr = 25'h0E000; dma_req = 1'b1;
    repeat (5) @(negedge clk_sys);
    checks++;
    if (mem_req !== 1'b1 || grant !== 2'b10) begin
      errors++; $display("FAIL rstmid_pre: got %b/%b want 1/10", mem_req, grant);
    end
    reset_n = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (mem_req !== 1'b0 || grant !== 2'b00 || rdata !== 8'h00 || dma_ack !== 1'b0) begin
      errors++; $display("FAIL rstmid_state: got %b/%b/%h/%b want 0/00/00/0", mem_req, grant, rdata, dma_ack);
    end
    reset_n = 1'b1; sram_dead = 1'b0; sram_lat = 2;
    for (t = 1; t <= 20; t++) begin @(negedge clk_sys); if (dma_ack) break; end
    checks++;
    if (!dma_ack || rdata !== fdata(25'h0E000)) begin
      errors++; $display("FAIL rstmid_regrant: got ack %b rdata %h want 1/%h", dma_ack, rdata, fdata(25'h0E000));
    end
    dma_req = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_protocol();
    checks++;
    if (multi_ack != 0 || ack_grant_bad != 0 || long_ack != 0) begin
      errors++; $display("FAIL ack_protocol: got %0d/%0d/%0d want 0/0/0", multi_ack, ack_grant_bad, long_ack);
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL mem_stable: got %0d changes want 0", unstable); end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_dma_read();
    test_priority();
    test_starvation();
    test_random();
    test_timeout();
    test_coincide();
    test_reset_mid();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
